fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the synchronous instruction ROM (1-cycle read, holds data while enable low).
//  - Owns the fetch PC and drives the ROM enable/address.
//  - Presents fetched words to decode over a valid/ready handshake.
//  - Handles redirects (branch/jump/trap) and halt; sits between the ROM and the decode stage.
// PARAMETERS
//  RESET_PC  30'h0  word address of the first fetch after reset
// PORTS
//  clk             in   1   clock; all logic rising-edge
//  rst             in   1   reset, synchronous, active-high
//  imem_en         out  1   ROM read enable (one read per high cycle)
//  imem_pc         out  30  ROM word address (combinational, see below)
//  imem_inst       in   32  ROM data, valid the cycle after imem_en=1, held while imem_en=0
//  redirect_valid  in   1   load new fetch PC this cycle, discard in-flight word
//  redirect_pc     in   30  target word address
//  halt_req        in   1   stop issuing fetches (level)
//  if_valid        out  1   if_inst/if_pc hold a valid instruction
//  if_ready        in   1   decode accepts when if_valid & if_ready
//  if_pc           out  30  word address of if_inst
//  if_inst         out  32  instruction (= imem_inst)
//  halted          out  1   high in HALT state
// BEHAVIOUR
//  - Registers: state{BOOT,RUN,HALT}, npc[29:0] (next sequential PC), r_pc[29:0], r_vld.
//  - Reset (rst=1 at edge): state=BOOT, npc=RESET_PC, r_pc=RESET_PC, r_vld=0.
//    Outputs: if_valid=0, imem_en=0, halted=0, if_pc=RESET_PC.
//  - imem_pc = redirect_valid ? redirect_pc : npc.
//  - issue (=imem_en), evaluated in priority order, first match wins:
//    - rst -> 0
//    - else redirect_valid -> 1
//    - else state==HALT or halt_req -> 0
//    - else (!r_vld | if_ready).
//  - On issue edge: r_pc<=imem_pc; npc<=imem_pc+1 (30-bit wrap, 3FFFFFFF->0); r_vld<=1.
//  - No issue: r_vld<=0 if if_valid & if_ready, else hold.
//  - if_valid = r_vld & ~redirect_valid & ~rst. The word under redirect is killed in the same cycle.
//  - if_pc=r_pc, if_inst=imem_inst; both held stable while if_valid & ~if_ready.
//  - Latency: 1 cycle from issue to if_valid; throughput 1 instr/cycle with if_ready held high.
//  - FSM:
//    - BOOT -> RUN after one cycle. BOOT issues RESET_PC unless halt_req, in which case it goes to HALT.
//    - RUN -> HALT when halt_req & ~redirect_valid.
//    - HALT -> RUN on redirect_valid. halt_req is ignored in HALT; redirect always wins.
//  - Entering HALT: a pending r_vld word is still delivered; no new issue; halted=1 from the next cycle.
//  - Redirect with r_vld & if_ready in the same cycle: not a handshake (if_valid=0); the new target is fetched.
//  - Back-to-back redirects: each one overrides; only the last target's word reaches decode.
//  - Mid-operation rst: all state cleared next edge, in-flight word dropped, no handshake during rst.
// CONFIGURATION
//  FETCH_CTRL_PERF_EN defined:
//    - Adds outputs perf_fetch[31:0], perf_stall[31:0], perf_flush[31:0]. All zero on rst, wrap at 2^32.
//    - perf_fetch: +1 per if_valid & if_ready.
//    - perf_stall: +1 per cycle with if_valid & ~if_ready.
//    - perf_flush: +1 per cycle with redirect_valid & r_vld.
//  FETCH_CTRL_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Reset release, RESET_PC=0x10, if_ready=1.
//    -> imem_pc 0x10,0x11,0x12 on consecutive cycles; if_valid=1 from cycle 2, if_pc follows 1 cycle behind.
//  2 if_ready=0 for 3 cycles at if_pc=0x12.
//    -> imem_en=0, if_pc/if_inst stable for 3 cycles; fetch of 0x13 issues the cycle if_ready returns.
//  3 redirect_valid=1, redirect_pc=0x80 while if_valid=1.
//    -> if_valid=0 that cycle, imem_pc=0x80; next cycle if_pc=0x80 and if_inst=rom[0x80].
//  4 halt_req pulse in RUN with r_vld=1.
//    -> pending word delivered, halted=1, imem_en=0 indefinitely; redirect to 0x40 -> RUN, if_pc=0x40.
//  5 redirect_pc=0x3FFFFFFF, then sequential fetch.
//    -> next imem_pc=0x0 (wrap).
//  6 rst asserted mid-stream with if_ready=0.
//    -> next cycle if_valid=0, imem_en=0; after release, fetch restarts at RESET_PC.
//    -> With FETCH_CTRL_PERF_EN: counters read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between a synchronous instruction
// ROM (1-cycle read, output held while enable is low) and the decode stage.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   imem_en / imem_pc        ROM read enable and word address (imem_pc is combinational)
//   imem_inst                ROM data, valid the cycle after imem_en
//   redirect_valid/_pc       load a new fetch PC, killing the word in flight
//   halt_req                 stop issuing fetches (level)
//   if_valid/if_ready        valid/ready handshake to decode
//   if_pc/if_inst            word address and instruction presented to decode
//   halted                   high while in HALT
//
// Optional feature macro FETCH_CTRL_PERF_EN adds perf_fetch, perf_stall and
// perf_flush event counters (32-bit, wrapping, cleared by rst).
module fetch_ctrl #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [29:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [29:0] if_pc,
  output logic [31:0] if_inst,
  output logic        halted
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [29:0] npc_q, npc_d;
  logic [29:0] r_pc_q, r_pc_d;
  logic        r_vld_q, r_vld_d;
  logic        issue;

  always_comb begin
    state_d = state_q;
    npc_d   = npc_q;
    r_pc_d  = r_pc_q;
    r_vld_d = r_vld_q;

    imem_pc  = redirect_valid ? redirect_pc : npc_q;
    // A redirect kills the word currently held, so it never handshakes.
    if_valid = r_vld_q & ~redirect_valid & ~rst;

    // Redirect beats halt; otherwise only issue when the output slot frees.
    if (rst)                                issue = 1'b0;
    else if (redirect_valid)                issue = 1'b1;
    else if (state_q == HALT || halt_req)   issue = 1'b0;
    else                                    issue = ~r_vld_q | if_ready;

    if (issue) begin
      r_pc_d  = imem_pc;
      npc_d   = imem_pc + 30'd1;
      r_vld_d = 1'b1;
    end else if (if_valid && if_ready) begin
      r_vld_d = 1'b0;
    end

    unique case (state_q)
      BOOT:    state_d = (halt_req && !redirect_valid) ? HALT : RUN;
      RUN:     if (halt_req && !redirect_valid) state_d = HALT;
      HALT:    if (redirect_valid) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign imem_en = issue;
  assign if_pc   = r_pc_q;
  assign if_inst = imem_inst;   // ROM holds its output while imem_en is low
  assign halted  = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      npc_q   <= RESET_PC;
      r_pc_q  <= RESET_PC;
      r_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      r_pc_q  <= r_pc_d;
      r_vld_q <= r_vld_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, if_valid & if_ready};
    perf_stall_d = perf_stall_q + {31'd0, if_valid & ~if_ready};
    perf_flush_d = perf_flush_q + {31'd0, redirect_valid & r_vld_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl (RESET_PC = 0x10): directed scenarios plus a
// randomized run checked against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  logic        clk, rst, imem_en, redirect_valid, halt_req, if_valid, if_ready, halted;
  logic [29:0] imem_pc, redirect_pc, if_pc;
  logic [31:0] imem_inst, if_inst, rom_q;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
  logic [31:0] m_pf = 0, m_ps = 0, m_pfl = 0;
`endif

  int nchk = 0, errs = 0;

  fetch_ctrl #(.RESET_PC(30'h10)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .halted(halted)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_C3C3;
  endfunction

  // Synchronous ROM: one read per enabled cycle, output held otherwise.
  initial rom_q = 32'd0;
  always @(posedge clk) if (imem_en) rom_q <= rom_f(imem_pc);
  assign imem_inst = rom_q;

  // Behavioural model: next fetch address, the word held for decode, halt flag.
  logic [29:0] m_npc = 30'h10, m_wpc = 30'h10, exp_pc;
  logic        m_have = 0, m_halt = 0, exp_en, exp_vld;

  task automatic drive(input logic r, input logic rv, input logic [29:0] rpc,
                       input logic hr, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; halt_req = hr; if_ready = rdy;
    #1;
    exp_pc  = rv ? rpc : m_npc;
    exp_en  = r ? 1'b0 : rv ? 1'b1 : (m_halt || hr) ? 1'b0 : (!m_have || rdy);
    exp_vld = m_have && !rv && !r;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_npc = 30'h10; m_wpc = 30'h10; m_have = 0; m_halt = 0;
`ifdef FETCH_CTRL_PERF_EN
      m_pf = 0; m_ps = 0; m_pfl = 0;
`endif
    end else begin
`ifdef FETCH_CTRL_PERF_EN
      if (exp_vld && if_ready) m_pf++;
      if (exp_vld && !if_ready) m_ps++;
      if (redirect_valid && m_have) m_pfl++;
`endif
      if (exp_en) begin m_wpc = exp_pc; m_npc = exp_pc + 30'd1; m_have = 1; end
      else if (exp_vld && if_ready) m_have = 0;
      m_halt = redirect_valid ? 1'b0 : (m_halt || halt_req);
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 1);
    nchk++; if ({if_valid, imem_en, halted} !== 3'b000) begin errs++;
      $display("FAIL reset_ctl got v/en/h=%b exp=000", {if_valid, imem_en, halted}); end
    nchk++; if (if_pc !== 30'h10) begin errs++;
      $display("FAIL reset_pc got=%h exp=10", if_pc); end
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      nchk++; if (imem_en !== 1'b1 || imem_pc !== 30'h10 + 30'(i)) begin errs++;
        $display("FAIL stream_issue[%0d] got en=%b pc=%h exp en=1 pc=%h", i, imem_en, imem_pc, 30'h10 + 30'(i)); end
      nchk++; if (if_valid !== (i >= 1)) begin errs++;
        $display("FAIL stream_valid[%0d] got=%b exp=%b", i, if_valid, i >= 1); end
      if (i >= 1) begin
        nchk++; if (if_pc !== 30'h10 + 30'(i - 1) || if_inst !== rom_f(30'h10 + 30'(i - 1))) begin errs++;
          $display("FAIL stream_word[%0d] got pc=%h inst=%h", i, if_pc, if_inst); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      nchk++; if ({imem_en, if_valid} !== 2'b01 || if_pc !== 30'h12 || if_inst !== rom_f(30'h12)) begin errs++;
        $display("FAIL stall[%0d] got en=%b v=%b pc=%h inst=%h exp en=0 v=1 pc=12 inst=%h",
                 i, imem_en, if_valid, if_pc, if_inst, rom_f(30'h12)); end
      tick();
    end
    drive(0, 0, 0, 0, 1);
    nchk++; if (imem_en !== 1'b1 || imem_pc !== 30'h13) begin errs++;
      $display("FAIL stall_resume got en=%b pc=%h exp en=1 pc=13", imem_en, imem_pc); end
    tick();
  endtask

  task automatic test_redirect();
    drive(0, 1, 30'h80, 0, 1);
    nchk++; if (if_valid !== 1'b0 || imem_pc !== 30'h80 || imem_en !== 1'b1) begin errs++;
      $display("FAIL redir_kill got v=%b pc=%h en=%b exp v=0 pc=80 en=1", if_valid, imem_pc, imem_en); end
    tick();
    drive(0, 0, 0, 0, 0);
    nchk++; if (if_valid !== 1'b1 || if_pc !== 30'h80 || if_inst !== rom_f(30'h80)) begin errs++;
      $display("FAIL redir_word got v=%b pc=%h inst=%h exp v=1 pc=80 inst=%h", if_valid, if_pc, if_inst, rom_f(30'h80)); end
    tick();
  endtask

  task automatic test_halt();
    drive(0, 0, 0, 1, 0);   // halt pulse while the 0x80 word is still pending
    nchk++; if (imem_en !== 1'b0 || if_valid !== 1'b1 || halted !== 1'b0) begin errs++;
      $display("FAIL halt_req got en=%b v=%b h=%b exp en=0 v=1 h=0", imem_en, if_valid, halted); end
    tick();
    drive(0, 0, 0, 0, 1);
    nchk++; if (halted !== 1'b1 || if_valid !== 1'b1 || if_pc !== 30'h80 || imem_en !== 1'b0) begin errs++;
      $display("FAIL halt_deliver got h=%b v=%b pc=%h en=%b exp h=1 v=1 pc=80 en=0", halted, if_valid, if_pc, imem_en); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, i[0], 1);
      nchk++; if ({halted, if_valid, imem_en} !== 3'b100) begin errs++;
        $display("FAIL halt_idle[%0d] got h/v/en=%b exp=100", i, {halted, if_valid, imem_en}); end
      tick();
    end
    drive(0, 1, 30'h40, 1, 1);
    nchk++; if (imem_en !== 1'b1 || imem_pc !== 30'h40) begin errs++;
      $display("FAIL halt_redir got en=%b pc=%h exp en=1 pc=40", imem_en, imem_pc); end
    tick();
    drive(0, 0, 0, 0, 1);
    nchk++; if (halted !== 1'b0 || if_valid !== 1'b1 || if_pc !== 30'h40 || if_inst !== rom_f(30'h40)) begin errs++;
      $display("FAIL halt_resume got h=%b v=%b pc=%h exp h=0 v=1 pc=40", halted, if_valid, if_pc); end
    tick();
  endtask

  task automatic test_wrap();
    drive(0, 1, 30'h3FFF_FFFF, 0, 1); tick();
    drive(0, 0, 0, 0, 1);
    nchk++; if (imem_pc !== 30'h0 || imem_en !== 1'b1 || if_pc !== 30'h3FFF_FFFF) begin errs++;
      $display("FAIL wrap got pc=%h en=%b if_pc=%h exp pc=0 en=1 if_pc=3fffffff", imem_pc, imem_en, if_pc); end
    tick();
  endtask

  task automatic test_mid_reset();
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0);
    nchk++; if ({if_valid, imem_en} !== 2'b00) begin errs++;
      $display("FAIL rst_during got v/en=%b exp=00", {if_valid, imem_en}); end
    tick();
    drive(0, 0, 0, 0, 0);
    nchk++; if (if_valid !== 1'b0 || imem_en !== 1'b1 || imem_pc !== 30'h10 || halted !== 1'b0) begin errs++;
      $display("FAIL rst_restart got v=%b en=%b pc=%h h=%b exp v=0 en=1 pc=10 h=0", if_valid, imem_en, imem_pc, halted); end
`ifdef FETCH_CTRL_PERF_EN
    nchk++; if ({perf_fetch, perf_stall, perf_flush} !== 96'd0) begin errs++;
      $display("FAIL rst_perf got %0d/%0d/%0d exp 0/0/0", perf_fetch, perf_stall, perf_flush); end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [29:0] rpc;
      rpc = ($urandom_range(3) == 0) ? 30'h3FFF_FFFE + 30'($urandom_range(1)) : 30'($urandom);
      drive($urandom_range(63) == 0, $urandom_range(7) == 0, rpc, $urandom_range(11) == 0,
            $urandom_range(3) != 0);
      nchk++; if ({imem_en, imem_pc, if_valid, if_pc, halted} !== {exp_en, exp_pc, exp_vld, m_wpc, m_halt}) begin errs++;
        $display("FAIL rand_ctl[%0d] got en=%b pc=%h v=%b if_pc=%h h=%b exp en=%b pc=%h v=%b if_pc=%h h=%b",
                 i, imem_en, imem_pc, if_valid, if_pc, halted, exp_en, exp_pc, exp_vld, m_wpc, m_halt); end
      if (exp_vld) begin
        nchk++; if (if_inst !== rom_f(m_wpc)) begin errs++;
          $display("FAIL rand_inst[%0d] got=%h exp=%h", i, if_inst, rom_f(m_wpc)); end
      end
`ifdef FETCH_CTRL_PERF_EN
      nchk++; if ({perf_fetch, perf_stall, perf_flush} !== {m_pf, m_ps, m_pfl}) begin errs++;
        $display("FAIL rand_perf[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", i, perf_fetch, perf_stall,
                 perf_flush, m_pf, m_ps, m_pfl); end
`endif
      tick();
    end
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; halt_req = 0; if_ready = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
